keypad_scanner: RTL and testbench

Reads a 4x4 membrane keypad, which gives the snake game its direction, pause and restart input. It is the input-side counterpart of the LED-matrix scan drivers: it drives one active-low column at a time and samples the active-low row lines. Each frame is debounced and filtered down to a single legal key, then reported as a registered code with a one-cycle valid pulse. It sits between the board pins and the game FSM.

---
 rtl/keypad_pkg.sv | 51 +++++
 rtl/keypad_col_driver.sv | 71 +++++++
 rtl/keypad_scanner.sv | 150 +++++++++++++++
 tb/tb_keypad_scanner.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its consumers.
// Key codes are col*4 + row, matching the scanner's key_code output.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } kp_state_e;

  typedef enum logic [1:0] {
    EMPTY,
    SINGLE,
    MULTI
  } frame_class_e;

  typedef struct packed {
    frame_class_e cls;
    logic [3:0]   key;
  } frame_info_t;

  localparam logic [3:0] KEY_UP    = 4'd1;
  localparam logic [3:0] KEY_LEFT  = 4'd4;
  localparam logic [3:0] KEY_RIGHT = 4'd6;
  localparam logic [3:0] KEY_DOWN  = 4'd9;
  localparam logic [3:0] KEY_PAUSE = 4'd15;

  // key is only meaningful when cls == SINGLE
  function automatic frame_info_t classify_frame(input logic [15:0] frame);
    frame_info_t info;
    logic [4:0]  ones;
    ones     = '0;
    info.key = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (frame[i]) begin
        ones     = ones + 5'd1;
        info.key = 4'(i);
      end
    end
    if (ones == 5'd0) begin
      info.cls = EMPTY;
    end else if (ones == 5'd1) begin
      info.cls = SINGLE;
    end else begin
      info.cls = MULTI;
    end
    return info;
  endfunction

endpackage

// File: rtl/keypad_col_driver.sv
// Column scan engine: walks an active-low column strobe, synchronises the row
// lines and assembles a 16-bit frame of pressed keys (bit index = col*4 + row).
module keypad_col_driver #(
  parameter int unsigned SCAN_DIV = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_row,
  output logic [3:0]  key_col,
  output logic [15:0] frame,
  output logic        frame_done
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [3:0]       row_meta_q;
  logic [3:0]       row_sync_q;
  logic [3:0]       row_s;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       key_col_q, key_col_d;
  logic [15:0]      snapshot_q, snapshot_d;
  logic             sample;

  // Rows idle high (pull-ups), so the synchroniser resets to "nothing pressed".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= key_row;
      row_sync_q <= row_meta_q;
    end
  end

  assign row_s = ~row_sync_q;

  always_comb begin
    sample     = (div_cnt_q == DIV_LAST);
    div_cnt_d  = div_cnt_q + 1'b1;
    col_idx_d  = col_idx_q;
    snapshot_d = snapshot_q;
    if (sample) begin
      div_cnt_d = '0;
      col_idx_d = col_idx_q + 2'd1;
      snapshot_d[{col_idx_q, 2'b00} +: 4] = row_s;
    end
    key_col_d = ~(4'b0001 << col_idx_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q  <= '0;
      col_idx_q  <= '0;
      key_col_q  <= 4'b1110;
      snapshot_q <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      col_idx_q  <= col_idx_d;
      key_col_q  <= key_col_d;
      snapshot_q <= snapshot_d;
    end
  end

  // Column 3 is merged in directly so the full frame is usable on frame_done itself.
  assign frame      = {row_s, snapshot_q[11:0]};
  assign frame_done = sample && (col_idx_q == 2'd3);
  assign key_col    = key_col_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad front end: classifies each scanned frame and debounces it down to
// one accepted key, reported as a registered code with a one-cycle valid pulse.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 5000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DEB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_SCANS);
  localparam logic [DEB_W-1:0] DEB_ONE = DEB_W'(1);

  logic [15:0]      frame;
  logic             frame_done;
  frame_info_t      info;
  logic             is_empty;
  logic             is_single;

  kp_state_e        state_q, state_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [DEB_W-1:0] deb_inc;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  keypad_col_driver #(
    .SCAN_DIV(SCAN_DIV)
  ) u_col_driver (
    .clk       (clk),
    .rst       (rst),
    .key_row   (key_row),
    .key_col   (key_col),
    .frame     (frame),
    .frame_done(frame_done)
  );

  assign info      = classify_frame(frame);
  assign is_empty  = (info.cls == EMPTY);
  assign is_single = (info.cls == SINGLE);
  assign deb_inc   = (deb_cnt_q == DEB_MAX) ? deb_cnt_q : deb_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (frame_done) begin
      case (state_q)
        IDLE: begin
          if (is_single) begin
            cand_d = info.key;
            if (DEBOUNCE_SCANS == 1) begin
              key_code_d  = info.key;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              deb_cnt_d   = '0;
              state_d     = PRESSED;
            end else begin
              deb_cnt_d = DEB_ONE;
              state_d   = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (is_single && info.key == cand_q) begin
            deb_cnt_d = deb_inc;
            if (deb_inc == DEB_MAX) begin
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              deb_cnt_d   = '0;
              state_d     = PRESSED;
            end
          end else if (is_single) begin
            cand_d    = info.key;
            deb_cnt_d = DEB_ONE;
          end else begin
            deb_cnt_d = '0;
            state_d   = IDLE;
          end
        end
        // Ghosted/chorded frames still count as "something pressed" here.
        PRESSED: begin
          if (is_empty) begin
            if (DEBOUNCE_SCANS == 1) begin
              key_held_d = 1'b0;
              deb_cnt_d  = '0;
              state_d    = IDLE;
            end else begin
              deb_cnt_d = DEB_ONE;
              state_d   = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (is_empty) begin
            deb_cnt_d = deb_inc;
            if (deb_inc == DEB_MAX) begin
              key_held_d = 1'b0;
              deb_cnt_d  = '0;
              state_d    = IDLE;
            end
          end else begin
            deb_cnt_d = '0;
            state_d   = PRESSED;
          end
        end
        default: begin
          deb_cnt_d = '0;
          state_d   = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      deb_cnt_q   <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a frame-level keypad model drives key_row, a
// reference model queues expected accepts/releases, and a monitor checks them.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 3;
  localparam int unsigned FRAME    = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] mask = '0;

  int unsigned cyc;
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    logic [3:0]  code;
    int unsigned cyc;
  } acc_t;
  typedef struct {
    logic        val;
    int unsigned cyc;
  } held_t;
  acc_t  acc_q[$];
  held_t held_q[$];
  acc_t  acc_pop;
  held_t held_pop;

  // reference model state (frame granularity)
  bit         m_held = 1'b0;
  int         m_run  = 0;
  logic [3:0] m_cand = '0;

  // monitor state
  logic       prev_held = 1'b0;
  logic [3:0] mon_code  = '0;
  logic [3:0] exp_col;

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_row  (key_row),
    .key_col  (key_col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Passive membrane: a pressed key shorts its row to its column when driven low.
  always_comb begin
    key_row = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (mask[c*4+r] && !key_col[c]) key_row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Outcome due at the end of a frame whose pressed-key set is m.
  function automatic void model_frame(input logic [15:0] m, input int unsigned due);
    int         n;
    logic [3:0] k;
    n = $countones(m);
    k = '0;
    for (int i = 0; i < 16; i++) if (m[i]) k = 4'(i);
    if (!m_held) begin
      if (n == 1 && m_run > 0 && k == m_cand) m_run++;
      else if (n == 1) begin m_cand = k; m_run = 1; end
      else m_run = 0;
      if (m_run == DEB) begin
        m_held = 1'b1;
        m_run  = 0;
        acc_q.push_back('{m_cand, due});
        held_q.push_back('{1'b1, due});
      end
    end else begin
      if (n == 0) m_run++;
      else        m_run = 0;
      if (m_run == DEB) begin
        m_held = 1'b0;
        m_run  = 0;
        held_q.push_back('{1'b0, due});
      end
    end
  endfunction

  // Called on a negedge where cyc is a multiple of FRAME.
  task automatic run_frame(input logic [15:0] m);
    mask = m;
    model_frame(m, cyc + FRAME);
    repeat (FRAME) @(negedge clk);
  endtask

  task automatic run_frames(input logic [15:0] m, input int n);
    repeat (n) run_frame(m);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      prev_held = 1'b0;
      mon_code  = '0;
    end else begin
      exp_col = ~(4'b0001 << ((cyc / SCAN_DIV) % 4));
      check("key_col", key_col, exp_col);
      if (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin
        acc_pop = acc_q.pop_front();
        check("missing_valid", 0, 1);
      end
      if (key_valid) begin
        if (acc_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got key_valid=1 code=%0d expected no pulse (cycle %0d)",
                   key_code, cyc);
        end else begin
          acc_pop = acc_q.pop_front();
          check("valid_code", key_code, acc_pop.code);
          check("valid_cycle", cyc, acc_pop.cyc);
          mon_code = acc_pop.code;
        end
      end
      if (held_q.size() > 0 && held_q[0].cyc < cyc) begin
        held_pop = held_q.pop_front();
        check("missing_held_edge", 0, 1);
      end
      if (key_held !== prev_held) begin
        if (held_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_held_edge: got key_held=%0d expected %0d (cycle %0d)",
                   key_held, prev_held, cyc);
        end else begin
          held_pop = held_q.pop_front();
          check("held_value", key_held, held_pop.val);
          check("held_cycle", cyc, held_pop.cyc);
        end
        prev_held = key_held;
      end
      if (cyc % FRAME == FRAME / 2) check("code_hold", key_code, mon_code);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          kind;
    int          len;
    int unsigned b1;
    int unsigned b2;
    logic [15:0] m;

    rst  = 1'b0;
    mask = '0;
    repeat (3) @(negedge clk);
    check("rst_key_col", key_col, 4'b1110);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_held", key_held, 0);
    check("rst_key_code", key_code, 0);
    rst = 1'b1;

    run_frames('0, 10);
    run_frames(16'h1 << KEY_DOWN, 5);
    run_frames('0, 4);

    run_frames(16'h1 << KEY_RIGHT, 2);
    run_frames('0, 1);
    run_frames(16'h1 << KEY_RIGHT, 3);
    run_frames('0, 4);

    run_frames((16'h1 << KEY_UP) | (16'h1 << KEY_LEFT), 6);
    run_frames(16'h1 << KEY_UP, 4);
    run_frames('0, 4);

    // Reset while two matching frames of key 5 are already in.
    run_frames(16'h1 << 5, 2);
    repeat (7) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_key_col", key_col, 4'b1110);
    check("midrst_key_valid", key_valid, 0);
    check("midrst_key_held", key_held, 0);
    check("midrst_key_code", key_code, 0);
    acc_q.delete();
    held_q.delete();
    m_held = 1'b0;
    m_run  = 0;
    m_cand = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_frames(16'h1 << 5, 4);
    run_frames('0, 4);

    repeat (40) begin
      kind = $urandom_range(0, 2);
      len  = $urandom_range(1, 5);
      b1   = $urandom_range(0, 15);
      b2   = (b1 + $urandom_range(1, 15)) % 16;
      case (kind)
        0:       m = '0;
        1:       m = 16'h1 << b1;
        default: m = (16'h1 << b1) | (16'h1 << b2);
      endcase
      run_frames(m, len);
    end
    run_frames('0, 4);
    repeat (2) @(negedge clk);
    check("acc_queue_drained", acc_q.size(), 0);
    check("held_queue_drained", held_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
